// File: rtl/shift_seq_ctrl_if.sv
// Handshake and data bundle between issue logic, the shift sequencer and writeback.
// Carries the request side (valid/ready, operands, flush) and the result side (valid/ready, data, busy).
// master = issue/writeback side driving requests, slave = sequencer.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             ConstVar;
  logic [1:0]       ShiftFn;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Shift_out;
  logic             busy;

  modport master (
    output in_valid, ConstVar, ShiftFn, x, y, flush, out_ready,
    input  in_ready, out_valid, Shift_out, busy
  );

  modport slave (
    input  in_valid, ConstVar, ShiftFn, x, y, flush, out_ready,
    output in_ready, out_valid, Shift_out, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: SLL/SRL/SRA/pass-through done as repeated shifts of <= MAX_STEP bits.
// Latency: result valid 1 + ceil(amt/MAX_STEP) cycles after the accepting cycle (amt saturated at WIDTH).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush drops the operation.
module shift_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  shift_seq_ctrl_if.slave    bus
);

  // Remaining-count width: must represent WIDTH itself, not just WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(MAX_STEP);
  localparam logic [CNT_W-1:0] FULL_V  = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [1:0] FN_SLL  = 2'b00;
  localparam logic [1:0] FN_SRL  = 2'b01;
  localparam logic [1:0] FN_SRA  = 2'b10;
  localparam logic [1:0] FN_PASS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_shift_out;
  logic [CNT_W-1:0] r_rem;
  logic [1:0]       r_fn;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_amt_raw;
  logic [CNT_W-1:0] w_amt;
  logic [CNT_W-1:0] w_step;
  logic [CNT_W-1:0] w_rem_next;
  logic [WIDTH-1:0] w_next;
  logic             w_accept;

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.Shift_out = r_shift_out;
  assign bus.busy      = r_busy;

  // flush in IDLE blocks acceptance for that cycle.
  assign w_accept = bus.in_valid && (r_state == S_IDLE) && !bus.flush;

  // Shift amount at acceptance: the full y is compared against WIDTH so large
  // amounts saturate rather than wrapping through the truncated low bits.
  always_comb begin
    w_amt_raw = bus.ConstVar ? bus.y : {{(WIDTH-1){1'b0}}, bus.y[0]};
    if (bus.ShiftFn == FN_PASS) begin
      w_amt = '0;
    end else if (w_amt_raw >= WIDTH_V) begin
      w_amt = FULL_V;
    end else begin
      w_amt = w_amt_raw[CNT_W-1:0];
    end
  end

  // One bounded step: never more than what remains, so the count cannot wrap.
  // SRA keeps the MSB fixed, so the arithmetic shift always fills with the captured sign.
  always_comb begin
    w_step     = (r_rem < STEP_V) ? r_rem : STEP_V;
    w_rem_next = r_rem - w_step;
    case (r_fn)
      FN_SLL:  w_next = r_data << w_step;
      FN_SRL:  w_next = r_data >> w_step;
      FN_SRA:  w_next = $unsigned($signed(r_data) >>> w_step);
      default: w_next = r_data;
    endcase
  end

  // Sequencer FSM with registered out_valid/busy/Shift_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_shift_out <= '0;
      r_rem       <= '0;
      r_fn        <= FN_SLL;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data <= bus.x;
            r_fn   <= bus.ShiftFn;
            r_rem  <= w_amt;
            r_busy <= 1'b1;
            if (w_amt == '0) begin
              // Nothing to shift: result is the operand itself, valid next cycle.
              r_state     <= S_DONE;
              r_shift_out <= bus.x;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (bus.flush) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_data <= w_next;
            r_rem  <= w_rem_next;
            if (w_rem_next == '0) begin
              r_state     <= S_DONE;
              r_shift_out <= w_next;
              r_out_valid <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // flush wins over a simultaneous output handshake; Shift_out keeps its value either way.
          if (bus.flush || bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (MAX_STEP=1 and MAX_STEP=4) driven with identical requests.
// Expected results come from a one-shot shift model and a ceil-division latency formula.
// Table vectors, hand-written corner sequences (flush, reset, stalls), then randomized operations.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(32)) if1 ();
  shift_seq_ctrl_if #(.WIDTH(32)) if4 ();

  shift_seq_ctrl #(.WIDTH(32), .MAX_STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  shift_seq_ctrl #(.WIDTH(32), .MAX_STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cv;
    logic [1:0]  fn;
    logic [31:0] x;
    logic [31:0] y;
    int          stall;
    bit          toggle;
    logic [31:0] exp_out;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic cv, input logic [1:0] fn,
                          input logic [31:0] xv, input logic [31:0] yv);
    if1.in_valid = v;  if4.in_valid = v;
    if1.ConstVar = cv; if4.ConstVar = cv;
    if1.ShiftFn  = fn; if4.ShiftFn  = fn;
    if1.x        = xv; if4.x        = xv;
    if1.y        = yv; if4.y        = yv;
  endtask

  task automatic set_ctl(input logic fl, input logic ordy);
    if1.flush = fl;     if4.flush = fl;
    if1.out_ready = ordy; if4.out_ready = ordy;
  endtask

  // Effective shift amount as an integer: pass-through is 0, anything >= 32 counts as 32.
  function automatic int ref_amt(input logic cv, input logic [1:0] fn, input logic [31:0] y);
    logic [31:0] a;
    a = cv ? y : {31'b0, y[0]};
    if (fn == 2'b11) return 0;
    if (a >= 32'd32) return 32;
    return int'(a);
  endfunction

  // One-shot shift; a shift by 32 yields 0 for the logical parts, which gives saturation directly.
  function automatic logic [31:0] ref_result(input logic cv, input logic [1:0] fn,
                                             input logic [31:0] x, input logic [31:0] y);
    int a;
    logic [31:0] ones;
    logic [31:0] fill;
    a = ref_amt(cv, fn, y);
    ones = 32'hFFFF_FFFF;
    fill = x[31] ? ~(ones >> a) : 32'h0;
    case (fn)
      2'b00:   return x << a;
      2'b01:   return x >> a;
      2'b10:   return (x >> a) | fill;
      default: return x;
    endcase
  endfunction

  function automatic int ref_lat(input int a, input int step);
    return 1 + (a + step - 1) / step;
  endfunction

  // Issue one op to both instances, measure latency, optionally stall in DONE, then hand it off.
  task automatic run_op(input string tag, input logic cv, input logic [1:0] fn,
                        input logic [31:0] xv, input logic [31:0] yv, input int stall,
                        input bit toggle, input logic [31:0] exp_out, input int e1, input int e4);
    int l1;
    int l4;
    logic [31:0] h1;
    logic [31:0] h4;
    chk({tag, " in_ready"}, {31'b0, if1.in_ready & if4.in_ready}, 32'd1);
    drive_in(1'b1, cv, fn, xv, yv);
    l1 = 0;
    l4 = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if1.in_valid = 1'b0; if4.in_valid = 1'b0;
      if (l1 == 0 && if1.out_valid) l1 = n;
      if (l4 == 0 && if4.out_valid) l4 = n;
      if (toggle)
        drive_in(1'b0, 1'($urandom), 2'($urandom), $urandom, $urandom);
      if (l1 != 0 && l4 != 0) break;
    end
    chk({tag, " lat1"}, 32'(l1), 32'(e1));
    chk({tag, " lat4"}, 32'(l4), 32'(e4));
    chk({tag, " out1"}, if1.Shift_out, exp_out);
    chk({tag, " out4"}, if4.Shift_out, exp_out);
    chk({tag, " busy"}, {31'b0, if1.busy & if4.busy}, 32'd1);
    h1 = if1.Shift_out;
    h4 = if4.Shift_out;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, {31'b0, if1.out_valid & if4.out_valid}, 32'd1);
      chk({tag, " hold out1"}, if1.Shift_out, h1);
      chk({tag, " hold out4"}, if4.Shift_out, h4);
    end
    set_ctl(1'b0, 1'b1);
    @(posedge clk); #1;
    set_ctl(1'b0, 1'b0);
    chk({tag, " post valid"}, {31'b0, if1.out_valid | if4.out_valid}, 32'd0);
    chk({tag, " post busy"}, {31'b0, if1.busy | if4.busy}, 32'd0);
    chk({tag, " post ready"}, {31'b0, if1.in_ready & if4.in_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_exp;
    logic        seen;
    logic        rc;
    logic [1:0]  rf;
    logic [31:0] rx;
    logic [31:0] ry;
    logic [31:0] re;
    int          ra;

    tbl[0]  = '{1'b1, 2'b00, 32'h0000_0001, 32'd5,          3, 1'b0, 32'h0000_0020, 6,  3};
    tbl[1]  = '{1'b1, 2'b10, 32'h8000_0000, 32'd40,         0, 1'b0, 32'hFFFF_FFFF, 33, 9};
    tbl[2]  = '{1'b1, 2'b01, 32'h8000_0000, 32'd40,         0, 1'b1, 32'h0000_0000, 33, 9};
    tbl[3]  = '{1'b0, 2'b01, 32'h0000_00F0, 32'h0000_0006,  0, 1'b0, 32'h0000_00F0, 1,  1};
    tbl[4]  = '{1'b0, 2'b01, 32'h0000_00F0, 32'h0000_0007,  1, 1'b0, 32'h0000_0078, 2,  2};
    tbl[5]  = '{1'b1, 2'b11, 32'h1234_5678, 32'd7,          0, 1'b0, 32'h1234_5678, 1,  1};
    tbl[6]  = '{1'b1, 2'b00, 32'h0000_0003, 32'd1,          0, 1'b0, 32'h0000_0006, 2,  2};
    tbl[7]  = '{1'b1, 2'b10, 32'hF000_0000, 32'd4,          0, 1'b1, 32'hFF00_0000, 5,  2};
    tbl[8]  = '{1'b1, 2'b00, 32'hFFFF_FFFF, 32'd32,         0, 1'b0, 32'h0000_0000, 33, 9};
    tbl[9]  = '{1'b1, 2'b10, 32'h7FFF_FFFF, 32'd31,         0, 1'b0, 32'h0000_0000, 32, 9};
    tbl[10] = '{1'b1, 2'b01, 32'h8000_0000, 32'd31,         2, 1'b0, 32'h0000_0001, 32, 9};
    tbl[11] = '{1'b1, 2'b00, 32'h0000_0001, 32'h0000_0041,  0, 1'b1, 32'h0000_0000, 33, 9};
    tbl[12] = '{1'b1, 2'b10, 32'h8000_0001, 32'd3,          0, 1'b0, 32'hF000_0000, 4,  2};
    tbl[13] = '{1'b1, 2'b11, 32'hDEAD_BEEF, 32'hFFFF_FFFF,  0, 1'b0, 32'hDEAD_BEEF, 1,  1};

    // Reset held for two cycles.
    rst = 1'b1;
    drive_in(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_ctl(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset out", if1.Shift_out | if4.Shift_out, 32'h0);
    chk("reset valid", {31'b0, if1.out_valid | if4.out_valid}, 32'd0);
    chk("reset busy", {31'b0, if1.busy | if4.busy}, 32'd0);
    chk("reset ready", {31'b0, if1.in_ready & if4.in_ready}, 32'd1);

    // Table vectors.
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].cv, tbl[i].fn, tbl[i].x, tbl[i].y,
             tbl[i].stall, tbl[i].toggle, tbl[i].exp_out, tbl[i].lat1, tbl[i].lat4);
    end
    last_exp = tbl[13].exp_out;

    // out_ready while nothing is valid has no effect.
    set_ctl(1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    set_ctl(1'b0, 1'b0);
    chk("idle ordy valid", {31'b0, if1.out_valid | if4.out_valid}, 32'd0);
    chk("idle ordy busy", {31'b0, if1.busy | if4.busy}, 32'd0);

    // flush in IDLE blocks acceptance.
    drive_in(1'b1, 1'b1, 2'b00, 32'h5, 32'd2);
    set_ctl(1'b1, 1'b0);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b1, 2'b00, 32'h5, 32'd2);
    set_ctl(1'b0, 1'b0);
    chk("idle flush busy", {31'b0, if1.busy | if4.busy}, 32'd0);
    chk("idle flush ready", {31'b0, if1.in_ready & if4.in_ready}, 32'd1);

    // Flush mid-shift, 4 cycles after acceptance.
    drive_in(1'b1, 1'b1, 2'b00, 32'h1, 32'd20);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b1, 2'b00, 32'h1, 32'd20);
    repeat (3) @(posedge clk);
    #1;
    chk("pre flush busy", {31'b0, if1.busy & if4.busy}, 32'd1);
    set_ctl(1'b1, 1'b0);
    @(posedge clk); #1;
    set_ctl(1'b0, 1'b0);
    chk("flush ready", {31'b0, if1.in_ready & if4.in_ready}, 32'd1);
    chk("flush valid", {31'b0, if1.out_valid | if4.out_valid}, 32'd0);
    chk("flush busy", {31'b0, if1.busy | if4.busy}, 32'd0);
    chk("flush keep out1", if1.Shift_out, last_exp);
    chk("flush keep out4", if4.Shift_out, last_exp);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (if1.out_valid || if4.out_valid) seen = 1'b1;
    end
    chk("flush no valid", {31'b0, seen}, 32'd0);
    run_op("after flush", 1'b1, 2'b00, 32'd3, 32'd1, 0, 1'b0, 32'd6, 2, 2);

    // flush in DONE wins over out_ready.
    drive_in(1'b1, 1'b1, 2'b11, 32'hA5A5_0F0F, 32'd0);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("done valid", {31'b0, if1.out_valid & if4.out_valid}, 32'd1);
    set_ctl(1'b1, 1'b1);
    @(posedge clk); #1;
    set_ctl(1'b0, 1'b0);
    chk("done flush valid", {31'b0, if1.out_valid | if4.out_valid}, 32'd0);
    chk("done flush ready", {31'b0, if1.in_ready & if4.in_ready}, 32'd1);
    chk("done flush out1", if1.Shift_out, 32'hA5A5_0F0F);
    chk("done flush out4", if4.Shift_out, 32'hA5A5_0F0F);

    // Reset in SHIFT.
    drive_in(1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'd20);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre rst busy", {31'b0, if1.busy & if4.busy}, 32'd1);
    rst = 1'b1;
    set_ctl(1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_ctl(1'b0, 1'b0);
    chk("mid rst out", if1.Shift_out | if4.Shift_out, 32'h0);
    chk("mid rst valid", {31'b0, if1.out_valid | if4.out_valid}, 32'd0);
    chk("mid rst busy", {31'b0, if1.busy | if4.busy}, 32'd0);
    chk("mid rst ready", {31'b0, if1.in_ready & if4.in_ready}, 32'd1);

    // Randomized operations against the model, with inputs scrambled after acceptance.
    for (int k = 0; k < 80; k++) begin
      rc = 1'($urandom);
      rf = 2'($urandom);
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = 32'($urandom_range(0, 8));
        1:       ry = 32'($urandom_range(0, 40));
        2:       ry = $urandom;
        default: ry = 32'($urandom_range(28, 33));
      endcase
      ra = ref_amt(rc, rf, ry);
      re = ref_result(rc, rf, rx, ry);
      run_op($sformatf("rnd%0d", k), rc, rf, rx, ry, int'($urandom_range(0, 2)),
             1'($urandom), re, ref_lat(ra, 1), ref_lat(ra, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
